// File: rtl/sbox_sweep_if.sv
// Bus bundle between the S-box sweep engine and its controller / external S-box.
// slave = sweep engine side, master = controller and S-box side.
interface sbox_sweep_if;
    logic       start;
    logic       busy;
    logic       done;
    logic [5:0] sbox_x;
    logic [5:0] sbox_y;
    logic       bijective;
    logic       dup_valid;
    logic [5:0] first_dup;
    logic [6:0] fixed_cnt;
    logic [5:0] xor_sum;
    logic [5:0] rd_addr;
    logic [5:0] rd_data;

    modport slave (
        input  start, sbox_y, rd_addr,
        output busy, done, sbox_x, bijective, dup_valid, first_dup,
               fixed_cnt, xor_sum, rd_data
    );

    modport master (
        output start, sbox_y, rd_addr,
        input  busy, done, sbox_x, bijective, dup_valid, first_dup,
               fixed_cnt, xor_sum, rd_data
    );
endinterface

// File: rtl/sbox_sweep.sv
// Sweeps a 6-bit external S-box over inputs 0..LAST and gathers collision/fixed-point/XOR stats.
// Define SBOX_SWEEP_TABLE_EN to add a 64x6 capture table readable through rd_addr/rd_data.
module sbox_sweep #(
    parameter int unsigned LAST = 63
) (
    input  logic         clk,
    input  logic         rst,
    sbox_sweep_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    localparam logic [5:0] LAST_X = 6'(LAST);

    state_t      state_q, state_d;
    logic [5:0]  x_q, x_d;
    logic [63:0] seen_q, seen_d;
    logic        dup_q, dup_d;
    logic [5:0]  first_dup_q, first_dup_d;
    logic [6:0]  fixed_cnt_q, fixed_cnt_d;
    logic [5:0]  xor_sum_q, xor_sum_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            seen_q      <= '0;
            dup_q       <= 1'b0;
            first_dup_q <= '0;
            fixed_cnt_q <= '0;
            xor_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            seen_q      <= seen_d;
            dup_q       <= dup_d;
            first_dup_q <= first_dup_d;
            fixed_cnt_q <= fixed_cnt_d;
            xor_sum_q   <= xor_sum_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        seen_d      = seen_q;
        dup_d       = dup_q;
        first_dup_d = first_dup_q;
        fixed_cnt_d = fixed_cnt_q;
        xor_sum_d   = xor_sum_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = SWEEP;
                    x_d         = '0;
                    seen_d      = '0;
                    dup_d       = 1'b0;
                    first_dup_d = '0;
                    fixed_cnt_d = '0;
                    xor_sum_d   = '0;
                end
            end
            SWEEP: begin
                xor_sum_d = xor_sum_q ^ bus.sbox_y;
                if (bus.sbox_y == x_q) begin
                    fixed_cnt_d = fixed_cnt_q + 7'd1;
                end
                // Only the earliest colliding input is recorded.
                if (seen_q[bus.sbox_y] && !dup_q) begin
                    dup_d       = 1'b1;
                    first_dup_d = x_q;
                end
                seen_d[bus.sbox_y] = 1'b1;
                if (x_q == LAST_X) begin
                    state_d = DONE;
                end else begin
                    x_d = x_q + 6'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.sbox_x    = x_q;
    assign bus.bijective = ~dup_q;
    assign bus.dup_valid = dup_q;
    assign bus.first_dup = first_dup_q;
    assign bus.fixed_cnt = fixed_cnt_q;
    assign bus.xor_sum   = xor_sum_q;

`ifdef SBOX_SWEEP_TABLE_EN
    // Capture storage is deliberately left out of reset so it can map to RAM.
    logic [5:0] cap_q [64];
    logic [5:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (state_q == SWEEP) begin
            cap_q[x_q] <= bus.sbox_y;
        end
        rd_data_q <= cap_q[bus.rd_addr];
    end

    assign bus.rd_data = rd_data_q;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^bus.rd_addr;
    assign bus.rd_data    = '0;
`endif

endmodule

// File: tb/tb_sbox_sweep.sv
// Scoreboard bench for sbox_sweep: two instances (LAST=63 and LAST=7) driven by S-box stubs.
module tb_sbox_sweep;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc   = 0;
    int n_chk = 0;
    int n_err = 0;
    int mode63 = 0;
    int mode7  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    sbox_sweep_if if63();
    sbox_sweep_if if7();

    function automatic logic [5:0] stub(int m, logic [5:0] x);
        case (m)
            0:       return x;
            1:       return 6'd0;
            2:       return x ^ 6'd1;
            3:       return ~x;
            4:       return (x == 6'd7) ? 6'd0 : x;
            default: return x;
        endcase
    endfunction

    assign if63.sbox_y = stub(mode63, if63.sbox_x);
    assign if7.sbox_y  = stub(mode7, if7.sbox_x);

    sbox_sweep #(.LAST(63)) dut63 (.clk(clk), .rst(rst), .bus(if63.slave));
    sbox_sweep #(.LAST(7))  dut7  (.clk(clk), .rst(rst), .bus(if7.slave));

    typedef struct {
        int         cyc;
        logic       dup;
        logic [5:0] fd;
        logic [6:0] fc;
        logic [5:0] xs;
    } exp_t;

    exp_t q63[$];
    exp_t q7[$];

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(logic dup, logic [5:0] fd, logic [6:0] fc, logic [5:0] xs);
        exp_t e;
        e.cyc = 0;
        e.dup = dup;
        e.fd  = fd;
        e.fc  = fc;
        e.xs  = xs;
        return e;
    endfunction

    task automatic cmp_done(string tag, exp_t e, int c, logic busy, logic bij, logic dup,
                            logic [5:0] fd, logic [6:0] fc, logic [5:0] xs);
        chk({tag, "_done_cycle"}, c, e.cyc);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_bijective"}, bij, !e.dup);
        chk({tag, "_dup_valid"}, dup, e.dup);
        chk({tag, "_first_dup"}, fd, e.fd);
        chk({tag, "_fixed_cnt"}, fc, e.fc);
        chk({tag, "_xor_sum"}, xs, e.xs);
    endtask

    always @(negedge clk) begin : mon63
        exp_t e;
        if (!rst && if63.done) begin
            if (q63.size() == 0) begin
                chk("dut63_unexpected_done", 1, 0);
            end else begin
                e = q63.pop_front();
                cmp_done("dut63", e, cyc, if63.busy, if63.bijective, if63.dup_valid,
                         if63.first_dup, if63.fixed_cnt, if63.xor_sum);
            end
        end
    end

    always @(negedge clk) begin : mon7
        exp_t e;
        if (!rst && if7.done) begin
            if (q7.size() == 0) begin
                chk("dut7_unexpected_done", 1, 0);
            end else begin
                e = q7.pop_front();
                cmp_done("dut7", e, cyc, if7.busy, if7.bijective, if7.dup_valid,
                         if7.first_dup, if7.fixed_cnt, if7.xor_sum);
            end
        end
    end

    // Start is sampled at the edge after it is raised; done appears LAST+1 edges later.
    task automatic start63(exp_t e, bit push);
        @(posedge clk); #1;
        if (push) begin
            e.cyc = cyc + 65;
            q63.push_back(e);
        end
        if63.start = 1'b1;
        @(posedge clk); #1;
        if63.start = 1'b0;
    endtask

    task automatic start7(exp_t e);
        @(posedge clk); #1;
        e.cyc = cyc + 9;
        q7.push_back(e);
        if7.start = 1'b1;
        @(posedge clk); #1;
        if7.start = 1'b0;
    endtask

    task automatic wait_empty(int sel);
        int left;
        left = 0;
        for (int i = 0; i < 300; i++) begin
            left = (sel == 0) ? q63.size() : q7.size();
            if (left == 0) break;
            @(posedge clk);
        end
        left = (sel == 0) ? q63.size() : q7.size();
        chk("done_timeout_pending", left, 0);
        #1;
    endtask

    task automatic chk_idle_reset(string tag);
        chk({tag, "_busy"}, if63.busy, 0);
        chk({tag, "_done"}, if63.done, 0);
        chk({tag, "_sbox_x"}, if63.sbox_x, 0);
        chk({tag, "_dup_valid"}, if63.dup_valid, 0);
        chk({tag, "_first_dup"}, if63.first_dup, 0);
        chk({tag, "_fixed_cnt"}, if63.fixed_cnt, 0);
        chk({tag, "_xor_sum"}, if63.xor_sum, 0);
        chk({tag, "_bijective"}, if63.bijective, 1);
    endtask

    int exp_rd5;
    int exp_rd62;

    initial begin
        if63.start = 1'b0; if63.rd_addr = '0;
        if7.start  = 1'b0; if7.rd_addr  = '0;
`ifdef SBOX_SWEEP_TABLE_EN
        exp_rd5  = 4;
        exp_rd62 = 63;
`else
        exp_rd5  = 0;
        exp_rd62 = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk_idle_reset("reset");
        chk("reset_dut7_busy", if7.busy, 0);
        rst = 1'b0;

        // Identity: bijective, every point fixed.
        mode63 = 0;
        start63(mk(1'b0, 6'd0, 7'd64, 6'd0), 1'b1);
        wait_empty(0);
        repeat (3) @(posedge clk);
        #1;
        chk("ident_sbox_x_hold", if63.sbox_x, 63);
        chk("ident_fixed_hold", if63.fixed_cnt, 64);
        chk("ident_busy_after", if63.busy, 0);

        // Constant zero: first collision at x=1.
        mode63 = 1;
        start63(mk(1'b1, 6'd1, 7'd1, 6'd0), 1'b1);
        wait_empty(0);
        repeat (2) @(posedge clk);
        #1;
        chk("const0_first_dup_hold", if63.first_dup, 1);

        // x^1: bijective, no fixed points; then table readback.
        mode63 = 2;
        start63(mk(1'b0, 6'd0, 7'd0, 6'd0), 1'b1);
        wait_empty(0);
        if63.rd_addr = 6'd5;
        @(posedge clk); #1;
        chk("table_rd5", if63.rd_data, exp_rd5);
        if63.rd_addr = 6'd62;
        @(posedge clk); #1;
        chk("table_rd62", if63.rd_data, exp_rd62);

        // Complement: bijective, no fixed points.
        mode63 = 3;
        start63(mk(1'b0, 6'd0, 7'd0, 6'd0), 1'b1);
        wait_empty(0);

        // LAST=7 identity.
        mode7 = 0;
        start7(mk(1'b0, 6'd0, 7'd8, 6'd0));
        wait_empty(1);
        repeat (2) @(posedge clk);
        #1;
        chk("last7_sbox_x_stop", if7.sbox_x, 7);

        // LAST=7 with S(7)=0: collision at 7, xor of 0..6 then 0 gives 7.
        mode7 = 4;
        start7(mk(1'b1, 6'd7, 7'd7, 6'd7));
        wait_empty(1);

        // Abort a sweep with reset at cycle 20, then rerun.
        mode63 = 0;
        start63(mk(1'b0, 6'd0, 7'd64, 6'd0), 1'b1);
        repeat (20) @(posedge clk);
        #1;
        chk("pre_abort_busy", if63.busy, 1);
        rst = 1'b1;
        q63.delete();
        #1;
        chk_idle_reset("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (70) @(posedge clk);
        #1;
        chk("abort_still_idle", if63.busy, 0);
        start63(mk(1'b0, 6'd0, 7'd64, 6'd0), 1'b1);
        wait_empty(0);

        // Extra starts during the sweep must be ignored.
        mode63 = 1;
        start63(mk(1'b1, 6'd1, 7'd1, 6'd0), 1'b1);
        repeat (10) @(posedge clk);
        start63(mk(1'b0, 6'd0, 7'd0, 6'd0), 1'b0);
        repeat (30) @(posedge clk);
        start63(mk(1'b0, 6'd0, 7'd0, 6'd0), 1'b0);
        wait_empty(0);
        repeat (80) @(posedge clk);
        #1;
        chk("ignored_start_idle", if63.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
